led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Sequencing controller for the 24-LED output bank. It holds a selected display mode and steps a registered LED pattern at a programmable rate derived from the board clock. It is the single driver of the `led[23:0]` bus that top-level source modules expose to the board. It provides start/stop control, a busy flag, and per-step and per-cycle status pulses for higher-level control and for simulation checks.

## Interface
Parameters:
- `CNT_MAX`, 25_000_000: clock cycles per pattern step; legal range 2..2^26. Simulation uses 4.
- `WIDTH`, 24: LED count; fixed at 24 for this board, not to be overridden.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  2  pattern select: 00 walk, 01 bounce, 10 blink, 11 fill. Sampled only when `start` is accepted.
- `start`  in  1  level-sampled start request; accepted only in IDLE.
- `stop`  in  1  level-sampled stop request; effective in any state.
- `led`  out  24  registered LED pattern.
- `busy`  out  1  high while in RUN; registered.
- `tick`  out  1  combinational; high in the cycle before each pattern step.
- `wrap`  out  1  registered one-cycle pulse; high after the step that completes a full pattern cycle.

## Operation
- States: IDLE, RUN. Reset enters IDLE.
- Reset values: `led`=0, `busy`=0, `wrap`=0, prescaler=0, latched mode=00, bounce direction=left. `tick`=0 because it is gated by RUN.
- IDLE:
  - `led` holds 0.
  - `start`=1 and `stop`=0 → RUN.
  - On that edge: latch `mode`, load the initial pattern, clear the prescaler, set direction=left, set `busy`=1.
- RUN:
  - Prescaler counts 0..CNT_MAX-1.
  - `tick` = RUN && prescaler==CNT_MAX-1.
  - On a tick edge, the prescaler returns to 0 and `led` advances.
  - `start` is ignored. Changes on `mode` are ignored until the next start.
- `stop`=1 in any state → IDLE on the next edge. On that edge `led`=0, `busy`=0, prescaler=0, `wrap`=0.
- Simultaneous `start` and `stop`: stop wins; the block stays in or returns to IDLE.
- Initial pattern by mode: walk 0x000001, bounce 0x000001, blink 0xFFFFFF, fill 0x000001.
- Step rules:
  - walk: rotate left by 1; bit23 → bit0. `wrap` on the 0x800000 → 0x000001 step.
  - bounce: single bit moves in the current direction.
    - Direction flips to right on reaching bit23 and to left on reaching bit0; the flip is applied in the same step as the arrival.
    - Sequence: 1, 2, …, 0x800000, 0x400000, …, 1.
    - `wrap` on the 0x000002 → 0x000001 step.
  - blink: `led` = ~`led` (0xFFFFFF ↔ 0). `wrap` on the 0 → 0xFFFFFF step.
  - fill: `led` = (`led`<<1)|1 until 0xFFFFFF; then → 0x000001. `wrap` on the 0xFFFFFF → 0x000001 step.
- `led` is never all-zero in RUN except in the blink off phase.

## Timing
- Start accepted at edge N: `busy`=1 and initial pattern visible after edge N.
- First `tick` is high during cycle N+CNT_MAX-1; first step occurs at edge N+CNT_MAX; steps then recur every CNT_MAX cycles.
- `wrap` is high for exactly the one cycle following its step edge.
- Stop at edge M: `led`=0 and `busy`=0 after edge M; `tick`=0 from that cycle on.
- Reset mid-RUN: outputs take reset values immediately, independent of the clock.
- Restart after stop: the pattern sequence begins fresh from the initial pattern and direction; no state is carried over.
- Prescaler width is ceil(log2(CNT_MAX)). No overflow beyond CNT_MAX-1.

## Test plan
All scenarios use CNT_MAX=4.
- Reset, then idle for 10 cycles → `led`=0, `busy`=0, `tick`=0, `wrap`=0 throughout.
- Start with mode=00 → `led`=0x000001 after the start edge; 0x000002 four cycles later; after 24 steps, back at 0x000001 with one `wrap` pulse.
- Start with mode=01, run 47 steps → `led` reaches 0x800000 at step 23, then 0x400000; returns to 0x000001 at step 46 with `wrap`; step 47 gives 0x000002.
- Start with mode=10 → `led` alternates 0xFFFFFF / 0x000000 every 4 cycles; `wrap` on each return to 0xFFFFFF.
- Start with mode=11, change `mode` to 00 mid-run → sequence 1, 3, 7, …, 0xFFFFFF, 1 continues unaffected.
- Assert `start` and `stop` together in IDLE → remains IDLE. Assert `stop` mid-fill → `led`=0 on the next edge. Assert `rst` asynchronously mid-walk → outputs clear before the next edge.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Sequencing controller for the 24-LED bank: holds a display mode latched at start
// and steps a registered pattern once every CNT_MAX clock cycles while running.
module led_seq_ctrl #(
  parameter int CNT_MAX = 25_000_000,
  parameter int WIDTH   = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] led,
  output logic             busy,
  output logic             tick,
  output logic             wrap
);

  localparam int PW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CNT_MAX - 1);
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TOP        = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {M_WALK, M_BOUNCE, M_BLINK, M_FILL} mode_t;

  state_t           state, state_n;
  mode_t            mode_q, mode_n;
  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] led_n, step_led;
  logic             busy_n, wrap_n;
  logic             dir, dir_n, step_dir, step_wrap;

  function automatic logic [WIDTH-1:0] init_pattern(input mode_t m);
    return (m == M_BLINK) ? '1 : ONE;
  endfunction

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  // Next pattern for the latched mode; dir=0 means the bounce bit moves left.
  always_comb begin
    step_led  = led;
    step_dir  = dir;
    step_wrap = 1'b0;
    case (mode_q)
      M_WALK: begin
        step_led  = {led[WIDTH-2:0], led[WIDTH-1]};
        step_wrap = (led == TOP);
      end
      M_BOUNCE: begin
        if (!dir) begin
          step_led = led << 1;
          step_dir = step_led[WIDTH-1];
        end else begin
          step_led  = led >> 1;
          step_dir  = !step_led[0];
          step_wrap = step_led[0];
        end
      end
      M_BLINK: begin
        step_led  = ~led;
        step_wrap = (led == '0);
      end
      M_FILL: begin
        if (led == '1) begin
          step_led  = ONE;
          step_wrap = 1'b1;
        end else begin
          step_led = {led[WIDTH-2:0], 1'b1};
        end
      end
      default: step_led = led;
    endcase
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    presc_n = presc;
    led_n   = led;
    busy_n  = busy;
    wrap_n  = 1'b0;
    dir_n   = dir;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n = RUN;
          mode_n  = mode_t'(mode);
          led_n   = init_pattern(mode_t'(mode));
          presc_n = '0;
          dir_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          presc_n = '0;
          led_n   = step_led;
          dir_n   = step_dir;
          wrap_n  = step_wrap;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    // Stop overrides everything, including a simultaneous start.
    if (stop) begin
      state_n = IDLE;
      led_n   = '0;
      busy_n  = 1'b0;
      presc_n = '0;
      wrap_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= M_WALK;
      presc  <= '0;
      led    <= '0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      dir    <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      presc  <= presc_n;
      led    <= led_n;
      busy   <= busy_n;
      wrap   <= wrap_n;
      dir    <= dir_n;
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: a vector table, directed multi-cycle scenarios and random
// start/stop/mode traffic, all checked against a pattern-table reference model.
module tb_led_seq_ctrl;

  localparam int CNT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] led;
  logic        busy, tick, wrap;

  int checks = 0;
  int failures = 0;

  led_seq_ctrl #(.CNT_MAX(CNT), .WIDTH(24)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .stop(stop),
    .led(led), .busy(busy), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Reference model: each mode is a list of patterns walked by index.
  logic [23:0] seqs [4][46];
  int          seq_len [4];
  bit          m_run;
  bit          m_wrap;
  int          m_cnt, m_idx;
  logic [1:0]  m_mode;

  typedef struct {
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [23:0] led;
    logic        busy;
    logic        tick;
    logic        wrap;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wrap = 0; m_cnt = 0; m_idx = 0; m_mode = 2'd0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (stop) begin
      m_run = 0; m_cnt = 0; m_wrap = 0;
    end else if (!m_run) begin
      m_wrap = 0;
      if (start) begin
        m_run = 1; m_mode = mode; m_idx = 0; m_cnt = 0;
      end
    end else if (m_cnt == CNT - 1) begin
      m_cnt  = 0;
      m_idx  = (m_idx + 1) % seq_len[m_mode];
      m_wrap = (m_idx == 0);
    end else begin
      m_cnt++;
      m_wrap = 0;
    end
  endtask

  task automatic check_model();
    chk("model_led", {8'h0, led}, {8'h0, m_run ? seqs[m_mode][m_idx] : 24'h0});
    chk("model_busy", {31'h0, busy}, {31'h0, m_run});
    chk("model_tick", {31'h0, tick}, {31'h0, m_run && (m_cnt == CNT - 1)});
    chk("model_wrap", {31'h0, wrap}, {31'h0, m_wrap});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int wraps;

    for (int i = 0; i < 24; i++) begin
      seqs[0][i] = 24'(1 << i);
      seqs[1][i] = 24'(1 << i);
      seqs[3][i] = 24'((1 << (i + 1)) - 1);
    end
    for (int i = 24; i < 46; i++) seqs[1][i] = 24'(1 << (46 - i));
    seqs[2][0] = 24'hFFFFFF;
    seqs[2][1] = 24'h000000;
    seq_len[0] = 24; seq_len[1] = 46; seq_len[2] = 2; seq_len[3] = 24;
    model_reset();

    tbl[0]  = '{1'b1, 1'b0, 2'd0, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd2, 24'h000001, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 24'h000001, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 24'h000002, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 2'd0, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd1, 24'h000000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd2, 24'hFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 2'd2, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'd2, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'd2, 24'h000000, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 2'd2, 24'h000000, 1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 2'd2, 24'hFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 2'd2, 24'h000000, 1'b0, 1'b0, 1'b0};

    // Reset, then idle for 10 cycles.
    run(2);
    rst = 1'b0;
    run(10);

    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; mode = tbl[i].mode;
      cycle();
      chk($sformatf("tbl%0d_led", i), {8'h0, led}, {8'h0, tbl[i].led});
      chk($sformatf("tbl%0d_busy", i), {31'h0, busy}, {31'h0, tbl[i].busy});
      chk($sformatf("tbl%0d_tick", i), {31'h0, tick}, {31'h0, tbl[i].tick});
      chk($sformatf("tbl%0d_wrap", i), {31'h0, wrap}, {31'h0, tbl[i].wrap});
    end
    start = 0; stop = 0;
    run(2);

    // Walk: full 24-step cycle with exactly one wrap.
    start = 1; mode = 2'd0; cycle(); start = 0;
    chk("walk_init", {8'h0, led}, 32'h000001);
    run(CNT);
    chk("walk_step1", {8'h0, led}, 32'h000002);
    wraps = 0;
    for (int i = 0; i < 23 * CNT; i++) begin
      cycle();
      if (wrap) wraps++;
    end
    chk("walk_back", {8'h0, led}, 32'h000001);
    chk("walk_wraps", wraps, 1);
    stop = 1; cycle(); stop = 0;

    // Bounce: 47 steps.
    start = 1; mode = 2'd1; cycle(); start = 0;
    for (int k = 1; k <= 47; k++) begin
      run(CNT);
      if (k == 23) chk("bounce_top", {8'h0, led}, 32'h800000);
      if (k == 24) chk("bounce_turn", {8'h0, led}, 32'h400000);
      if (k == 46) begin
        chk("bounce_home", {8'h0, led}, 32'h000001);
        chk("bounce_wrap", {31'h0, wrap}, 32'h1);
      end
      if (k == 47) chk("bounce_again", {8'h0, led}, 32'h000002);
    end
    stop = 1; cycle(); stop = 0;

    // Fill with mode changed mid-run, then stop mid-fill.
    start = 1; mode = 2'd3; cycle(); start = 0;
    mode = 2'd0;
    for (int k = 1; k <= 24; k++) begin
      run(CNT);
      chk($sformatf("fill_step%0d", k), {8'h0, led},
          (k == 24) ? 32'h000001 : ((32'h1 << (k + 1)) - 1));
    end
    chk("fill_wrap", {31'h0, wrap}, 32'h1);
    run(5);
    stop = 1; cycle(); stop = 0;
    chk("fill_stop_led", {8'h0, led}, 32'h0);
    chk("fill_stop_busy", {31'h0, busy}, 32'h0);

    // Asynchronous reset mid-walk.
    start = 1; mode = 2'd0; cycle(); start = 0;
    run(6);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_led", {8'h0, led}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_tick", {31'h0, tick}, 32'h0);
    chk("arst_wrap", {31'h0, wrap}, 32'h0);
    cycle();
    rst = 1'b0;
    run(3);
    // Restart after reset begins fresh.
    start = 1; mode = 2'd1; cycle(); start = 0;
    chk("restart_led", {8'h0, led}, 32'h000001);
    run(3 * CNT);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      mode  = 2'($urandom_range(0, 3));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
